mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
CPU-side initiator for the word-wide single-port data RAM (clk, ram_ena, wena, addr, data_in, combinational data_out).
- Accepts byte, halfword and word load/store requests from the MEM stage and turns them into RAM read/write cycles.
- Performs read-modify-write for sub-word stores, and extracts plus sign/zero-extends sub-word loads.
- Reports misaligned accesses without touching the RAM.

Parameters:
ADDR_BITS, 8, RAM word-address width; the RAM holds 2**ADDR_BITS words.
DATA_WIDTH, 32, RAM word width; fixed at 32 (byte-lane logic assumes 4 lanes).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
req_signed  input  1  sign-extend a sub-word load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  misaligned or illegal access, qualified by resp_valid
ram_ena  output  1  to RAM ram_ena
ram_wena  output  1  to RAM wena
ram_addr  output  ADDR_BITS  to RAM addr (word address)
ram_wdata  output  32  to RAM data_in
ram_rdata  input  32  from RAM data_out (combinational read)

Behaviour:
- States: IDLE, READ, WRITE, RESP, encoded in a registered state.
- req_ready = (state==IDLE) && !rst. A request is accepted on a clock edge where req_valid && req_ready; all req_* fields are latched at acceptance.
- Word address = req_addr[ADDR_BITS+1:2]. Lane = req_addr[1:0]. Little-endian: lane 0 = bits [7:0].
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - IDLE -> RESP with err=1.
  - ram_ena is never asserted for the request.
- IDLE transitions on accept:
  - load -> READ
  - word store -> WRITE
  - byte/half store -> READ (RMW)
  - error -> RESP
- READ: ram_ena=1, ram_wena=0, ram_addr=latched word address. ram_rdata is captured into an internal buffer at the end of the cycle. Next state: load -> RESP; sub-word store -> WRITE.
- WRITE: ram_ena=1, ram_wena=1.
  - ram_wdata = buffered word with the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
  - A word store writes req_wdata directly.
  - Next state: RESP.
- RESP: resp_valid=1 for exactly one cycle; next state IDLE.
- resp_rdata for loads: the selected byte/half, sign-extended if req_signed, else zero-extended; a word load returns the full word.
- Latency, from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- resp_rdata and resp_err are registered and hold their value until the next RESP. Both are 0 after reset.
- ram_ena, ram_wena, ram_addr and ram_wdata are decoded from state and latched fields. ram_ena/ram_wena are gated with !rst, so no RAM write occurs in any cycle where rst=1.
- Reset (synchronous, any state including mid-RMW): state <- IDLE, latched fields <- 0, resp_valid/resp_err/resp_rdata <- 0. An in-flight request is dropped with no response.
- Outside RESP: resp_valid=0. Outside READ/WRITE: ram_ena=0 and ram_wena=0.
- Address wrap: bits req_addr[31:ADDR_BITS+2] are ignored (aliasing), unless the optional feature is enabled.
- The next request can be accepted in the cycle after RESP (IDLE). There are no back-to-back accepts without RESP.

Optional Feature:
MEM_ACCESS_BOUNDS_CHECK_EN
- Defined: any nonzero bit in req_addr[31:ADDR_BITS+2] is treated as an error, identical to a misaligned access (1-cycle latency, no RAM access).
- Undefined: upper bits are ignored and addresses alias modulo 2**(ADDR_BITS+2).

Test Plan:
- Word 2 = 0x11223344; lw addr 0x8 -> ram_ena high 1 cycle with ram_addr=2, wena=0; resp_valid 2 cycles after accept, resp_rdata=0x11223344, resp_err=0.
- Word 3 = 0x80FF7F01; lb addr 0xE signed -> 0xFFFFFFFF; lbu addr 0xE -> 0x000000FF; lh addr 0xE signed -> 0xFFFF80FF; lhu addr 0xC -> 0x00007F01.
- sh 0x0000ABCD to addr 0xA over 0x11223344 -> READ then WRITE (wena high only in the 2nd cycle, ram_wdata=0xABCD3344); word 2 = 0xABCD3344; resp 3 cycles after accept.
- lw addr 0x6, sh addr 0x5, size 11 -> resp_err=1 and resp_rdata=0 one cycle after accept; ram_ena never asserts; memory unchanged.
- sb 0x55 to addr 0x8; assert rst for 1 cycle while in WRITE -> wena never high, word 2 unchanged, no resp_valid; req_ready=1 in the first cycle after rst falls.
- req_valid held high with lw 0x8 then lw 0x400 (ADDR_BITS=8) -> accepts spaced exactly 3 cycles apart. Second load: without MEM_ACCESS_BOUNDS_CHECK_EN returns word 0 (alias); with it, resp_err=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-wide single-port RAM with sub-word RMW.
// Optional: define MEM_ACCESS_BOUNDS_CHECK_EN to flag addresses beyond the RAM as errors.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  ram_ena,
  output logic                  ram_wena,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, signed_q;
  logic [1:0]            size_q, lane_q;
  logic [ADDR_BITS-1:0]  waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rbuf_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic                  accept_c, req_err_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] load_c, merged_c;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept_c  = req_valid && req_ready;

  // Alignment / legality decode of the incoming request
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      2'b00:   req_err_c = 1'b0;
      2'b01:   req_err_c = req_addr[0];
      2'b10:   req_err_c = |req_addr[1:0];
      default: req_err_c = 1'b1;
    endcase
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    if (|req_addr[31:ADDR_BITS+2]) req_err_c = 1'b1;
`endif
  end

`ifndef MEM_ACCESS_BOUNDS_CHECK_EN
  logic unused_upper_c;
  assign unused_upper_c = ^req_addr[31:ADDR_BITS+2];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (req_err_c)                           state_d = RESP;
          else if (req_we && (req_size == 2'b10)) state_d = WRITE;
          else                                     state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load extraction from the live RAM word (little-endian lanes)
  always_comb begin
    byte_c = ram_rdata[{lane_q, 3'b000} +: 8];
    half_c = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      2'b00:   load_c = {{24{signed_q & byte_c[7]}}, byte_c};
      2'b01:   load_c = {{16{signed_q & half_c[15]}}, half_c};
      default: load_c = ram_rdata;
    endcase
  end

  // Store merge: sub-word lanes patched into the word buffered during READ
  always_comb begin
    merged_c = rbuf_q;
    case (size_q)
      2'b00: merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane_q[1]) merged_c[31:16] = wdata_q[15:0];
        else           merged_c[15:0]  = wdata_q[15:0];
      end
      default: merged_c = wdata_q;
    endcase
  end

  assign ram_ena    = ((state_q == READ) || (state_q == WRITE)) && !rst;
  assign ram_wena   = (state_q == WRITE) && !rst;
  assign ram_addr   = waddr_q;
  assign ram_wdata  = merged_c;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      waddr_q      <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        lane_q   <= req_addr[1:0];
        waddr_q  <= req_addr[ADDR_BITS+1:2];
        wdata_q  <= req_wdata;
        if (req_err_c) begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b1;
        end
      end
      if (state_q == READ) begin
        rbuf_q <= ram_rdata;
        if (!we_q) begin
          resp_rdata_q <= load_c;
          resp_err_q   <= 1'b0;
        end
      end
      if (state_q == WRITE) begin
        resp_rdata_q <= '0;
        resp_err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a behavioural single-port RAM.
module tb_mem_access_unit;
  localparam int unsigned ADDR_BITS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, ram_ena, ram_wena;
  logic [31:0] resp_rdata, ram_wdata, ram_rdata;
  logic [ADDR_BITS-1:0] ram_addr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb_q[$];
  int          acc_q[$];
  logic [31:0] mem [0:255];
  int          cyc = 0;
  int          ena_cnt = 0, wena_cnt = 0, wena_cyc = 0;
  logic [ADDR_BITS-1:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  int          checks = 0, passed = 0;

  mem_access_unit #(.ADDR_BITS(ADDR_BITS), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_ena(ram_ena),
    .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
    if (req_valid && req_ready) acc_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (ram_ena) begin ena_cnt++; last_addr = ram_addr; end
    if (ram_wena) begin wena_cnt++; last_wdata = ram_wdata; wena_cyc = cyc; end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    mem[0] <= 32'hA5A5_0000;
    mem[2] <= 32'h1122_3344;
    mem[3] <= 32'h80FF_7F01;
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd, output logic er);
    bit got = 0;
    lat = 0; rd = 'x; er = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin got = 1; lat = n; rd = resp_rdata; er = resp_err; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || ram_ena !== 1'b0)
      $display("FAIL reset_ctrl ready/valid/ena=%b%b%b exp 000", req_ready, resp_valid, ram_ena);
    else passed++;
    checks++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0)
      $display("FAIL reset_resp rdata=%h err=%b exp 0/0", resp_rdata, resp_err);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp 1", req_ready);
    else passed++;
  endtask

  task automatic test_load();
    logic [31:0] ad [6] = '{32'h8, 32'hE, 32'hE, 32'hE, 32'hC, 32'hD};
    logic [1:0]  sz [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        sg [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ex [6] = '{32'h1122_3344, 32'hFFFF_FFFF, 32'h0000_00FF,
                            32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_007F};
    int lat, e0, w0;
    logic [31:0] rd;
    logic er;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e0 = ena_cnt; w0 = wena_cnt;
      sb_q.push_back('{rdata: ex[i], err: 1'b0, lat: 8'd2});
      do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, er);
      e = sb_q.pop_front();
      checks++;
      if (rd !== e.rdata) $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, e.rdata);
      else passed++;
      checks++;
      if (er !== e.err || lat != int'(e.lat))
        $display("FAIL load%0d_err_lat got=%b/%0d exp=%b/%0d", i, er, lat, e.err, e.lat);
      else passed++;
      checks++;
      if (ena_cnt - e0 != 1 || wena_cnt != w0 || last_addr !== ad[i][9:2])
        $display("FAIL load%0d_ram ena=%0d wena=%0d addr=%0d exp 1/0/%0d",
                 i, ena_cnt - e0, wena_cnt - w0, last_addr, ad[i][9:2]);
      else passed++;
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== e.rdata)
          $display("FAIL load_hold valid=%b rdata=%h exp 0/%h", resp_valid, resp_rdata, e.rdata);
        else passed++;
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] ad [3] = '{32'h6, 32'h5, 32'h8};
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic        we [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] m1, m2, rd;
    int lat, e0;
    logic er;
    exp_t e;
    m1 = mem[1]; m2 = mem[2];
    for (int i = 0; i < 3; i++) begin
      e0 = ena_cnt;
      sb_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 8'd1});
      do_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, lat, rd, er);
      e = sb_q.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err || lat != int'(e.lat))
        $display("FAIL misal%0d_resp got=%h/%b/%0d exp=%h/%b/%0d", i, rd, er, lat, e.rdata, e.err, e.lat);
      else passed++;
      checks++;
      if (ena_cnt != e0) $display("FAIL misal%0d_ena got=%0d exp 0", i, ena_cnt - e0);
      else passed++;
    end
    checks++;
    if (mem[1] !== m1 || mem[2] !== m2)
      $display("FAIL misal_mem got=%h/%h exp=%h/%h", mem[1], mem[2], m1, m2);
    else passed++;
  endtask

  task automatic test_store();
    logic [31:0] ad [3] = '{32'hA, 32'h10, 32'hD};
    logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b00};
    logic [31:0] wd [3] = '{32'h0000_ABCD, 32'hDEAD_BEEF, 32'h1234_565A};
    logic [31:0] xm [3] = '{32'hABCD_3344, 32'hDEAD_BEEF, 32'h80FF_5A01};
    logic [7:0]  xl [3] = '{8'd3, 8'd2, 8'd3};
    logic [31:0] rd;
    int lat, e0, w0;
    logic er;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e0 = ena_cnt; w0 = wena_cnt;
      sb_q.push_back('{rdata: 32'h0, err: 1'b0, lat: xl[i]});
      do_req(1'b1, sz[i], 1'b0, ad[i], wd[i], lat, rd, er);
      e = sb_q.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err || lat != int'(e.lat))
        $display("FAIL store%0d_resp got=%h/%b/%0d exp=%h/%b/%0d", i, rd, er, lat, e.rdata, e.err, e.lat);
      else passed++;
      checks++;
      if (mem[ad[i][9:2]] !== xm[i] || last_wdata !== xm[i])
        $display("FAIL store%0d_data mem=%h wdata=%h exp=%h", i, mem[ad[i][9:2]], last_wdata, xm[i]);
      else passed++;
      checks++;
      if (wena_cnt - w0 != 1 || ena_cnt - e0 != int'(xl[i]) - 1 ||
          wena_cyc - acc_q[$] != int'(xl[i]) - 1)
        $display("FAIL store%0d_ram wena=%0d ena=%0d wcyc=%0d exp 1/%0d/%0d", i,
                 wena_cnt - w0, ena_cnt - e0, wena_cyc - acc_q[$], xl[i] - 1, xl[i] - 1);
      else passed++;
    end
  endtask

  task automatic test_reset_rmw();
    logic [31:0] m2;
    int w0, rv;
    m2 = mem[2]; w0 = wena_cnt; rv = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) $display("FAIL rmw_rst_ready got=%b exp 1", req_ready);
    else passed++;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    checks++;
    if (wena_cnt != w0 || mem[2] !== m2 || rv != 0)
      $display("FAIL rmw_rst wena=%0d mem=%h resp=%0d exp 0/%h/0", wena_cnt - w0, mem[2], rv, m2);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n0, nresp;
    exp_t e;
    n0 = acc_q.size(); nresp = 0;
    sb_q.push_back('{rdata: 32'hABCD_3344, err: 1'b0, lat: 8'd2});
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    sb_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 8'd1});
`else
    sb_q.push_back('{rdata: 32'hA5A5_0000, err: 1'b0, lat: 8'd2});
`endif
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h8; req_wdata = '0;
    for (int n = 0; n < 20 && acc_q.size() < n0 + 1; n++) @(negedge clk);
    req_addr = 32'h400;
    for (int n = 0; n < 30 && nresp < 2; n++) begin
      @(negedge clk);
      if (acc_q.size() >= n0 + 2) req_valid = 1'b0;
      if (resp_valid) begin
        e = sb_q.pop_front();
        nresp++;
        checks++;
        if (resp_rdata !== e.rdata || resp_err !== e.err)
          $display("FAIL b2b%0d_resp got=%h/%b exp=%h/%b", nresp, resp_rdata, resp_err, e.rdata, e.err);
        else passed++;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (nresp != 2 || acc_q.size() != n0 + 2)
      $display("FAIL b2b_timeout resp=%0d acc=%0d exp 2/2", nresp, acc_q.size() - n0);
    else passed++;
    checks++;
    if (acc_q.size() != n0 + 2 || acc_q[n0 + 1] - acc_q[n0] != 3)
      $display("FAIL b2b_spacing got=%0d exp 3",
               (acc_q.size() >= n0 + 2) ? acc_q[n0 + 1] - acc_q[n0] : -1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_misaligned();
    test_store();
    test_reset_rmw();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
